// File: rtl/grid_pkg.sv
// Shared definitions for the level grid: cell codes, geometry, addressing and
// the rebuild sequencer states.
package grid_pkg;

    localparam logic [2:0] CELL_AIR   = 3'd0;
    localparam logic [2:0] CELL_WALL  = 3'd1;
    localparam logic [2:0] CELL_ENEMY = 3'd4;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    // Row-major linear address; out-of-range coordinates still map to an
    // 11-bit value, callers mask them with their own range check.
    function automatic logic [ADDR_W-1:0] grid_addr(input logic [5:0] x, input logic [4:0] y);
        return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/grid_ram.sv
// Simple dual-port grid memory: one read/write port, one read-only port,
// registered read-before-write outputs suitable for block RAM inference.
module grid_ram #(
    parameter int DEPTH  = 1200,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array: write only, never reset.
    always_ff @(posedge clock) begin
        if (a_we) begin
            mem_r[a_addr] <= a_wdata;
        end
    end

    // Output registers sample the pre-write contents on both ports.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_rdata <= '0;
            r_rdata <= '0;
        end else begin
            a_rdata <= mem_r[a_addr];
            r_rdata <= mem_r[r_addr];
        end
    end

endmodule

// File: rtl/grid_store.sv
// Level grid store: game-logic port A (read/write), renderer port R (read
// only), and a sequencer that rebuilds the walled empty arena on request.
module grid_store #(
    parameter int GRID_W = grid_pkg::GRID_W,
    parameter int GRID_H = grid_pkg::GRID_H
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    output logic       busy,
    output logic       init_done,
    input  logic [5:0] a_x,
    input  logic [4:0] a_y,
    input  logic       a_write,
    input  logic [2:0] a_in,
    output logic [2:0] a_out,
    input  logic [5:0] r_x,
    input  logic [4:0] r_y,
    output logic [2:0] r_out
);
    import grid_pkg::*;

    fill_state_t state_r;
    logic [5:0]  fx_r;
    logic [4:0]  fy_r;
    logic        busy_r;
    logic        init_done_r;
    logic        a_wall_r;
    logic        r_wall_r;

    logic              a_in_range_s;
    logic              r_in_range_s;
    logic              fill_last_s;
    logic              fill_edge_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_a_addr_s;
    logic [2:0]        ram_wdata_s;
    logic [2:0]        ram_a_q_s;
    logic [2:0]        ram_r_q_s;

    assign a_in_range_s = (a_x < 6'(GRID_W)) && (a_y < 5'(GRID_H));
    assign r_in_range_s = (r_x < 6'(GRID_W)) && (r_y < 5'(GRID_H));
    assign fill_last_s  = (fx_r == 6'(GRID_W - 1)) && (fy_r == 5'(GRID_H - 1));
    assign fill_edge_s  = (fx_r == 6'd0) || (fx_r == 6'(GRID_W - 1)) ||
                          (fy_r == 5'd0) || (fy_r == 5'(GRID_H - 1));

    // Write mux: the rebuild counter owns the write port while filling.
    always_comb begin
        ram_we_s     = 1'b0;
        ram_a_addr_s = grid_addr(a_x, a_y);
        ram_wdata_s  = a_in;
        if (reset) begin
            ram_we_s = 1'b0;
        end else if (state_r == ST_FILL) begin
            ram_we_s     = 1'b1;
            ram_a_addr_s = grid_addr(fx_r, fy_r);
            ram_wdata_s  = fill_edge_s ? CELL_WALL : CELL_AIR;
        end else begin
            ram_we_s = a_write && a_in_range_s;
        end
    end

    grid_ram #(
        .DEPTH  (GRID_W * GRID_H),
        .ADDR_W (ADDR_W),
        .DATA_W (3)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .a_addr  (ram_a_addr_s),
        .a_we    (ram_we_s),
        .a_wdata (ram_wdata_s),
        .a_rdata (ram_a_q_s),
        .r_addr  (grid_addr(r_x, r_y)),
        .r_rdata (ram_r_q_s)
    );

    // Rebuild sequencer with its x-major fill counter and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            fx_r        <= 6'd0;
            fy_r        <= 5'd0;
            busy_r      <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    init_done_r <= 1'b0;
                    if (init) begin
                        state_r <= ST_FILL;
                        busy_r  <= 1'b1;
                        fx_r    <= 6'd0;
                        fy_r    <= 5'd0;
                    end
                end
                ST_FILL: begin
                    if (fill_last_s) begin
                        state_r     <= ST_DONE;
                        busy_r      <= 1'b0;
                        init_done_r <= 1'b1;
                        fx_r        <= 6'd0;
                        fy_r        <= 5'd0;
                    end else if (fx_r == 6'(GRID_W - 1)) begin
                        fx_r <= 6'd0;
                        fy_r <= fy_r + 5'd1;
                    end else begin
                        fx_r <= fx_r + 6'd1;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    init_done_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    init_done_r <= 1'b0;
                    fx_r        <= 6'd0;
                    fy_r        <= 5'd0;
                end
            endcase
        end
    end

    // Wall overrides track the read that the RAM outputs are presenting.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_wall_r <= 1'b0;
            r_wall_r <= 1'b0;
        end else begin
            a_wall_r <= !a_in_range_s || (state_r == ST_FILL);
            r_wall_r <= !r_in_range_s;
        end
    end

    assign a_out     = a_wall_r ? CELL_WALL : ram_a_q_s;
    assign r_out     = r_wall_r ? CELL_WALL : ram_r_q_s;
    assign busy      = busy_r;
    assign init_done = init_done_r;

endmodule

// File: doc/grid_store.md
# grid_store

Holds the 40×30 level grid of 3-bit cell codes and serves memory requests from the game-logic clients, such as the enemy updater. It also serves the renderer. It has two ports:
- Port A is read/write, for game logic. Cell-update FSMs drive it with `grid_x`/`grid_y`/`grid_write`/`grid_in` and sample `grid_out`.
- Port R is read-only, for the VGA renderer.

An internal init sequencer rebuilds the empty arena (border walls, air interior) on request.

## Interface
Parameters:
- `GRID_W`, default 40: grid width in cells.
- `GRID_H`, default 30: grid height in cells.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: reset, synchronous, active-high. Clock is `clock`.
- `init`  in  1: single-cycle pulse that starts an arena rebuild.
- `busy`  out  1: high while the rebuild is in progress.
- `init_done`  out  1: one-cycle pulse after the last rebuild write.
- `a_x`  in  6: port A column.
- `a_y`  in  5: port A row.
- `a_write`  in  1: port A write enable.
- `a_in`  in  3: port A write data.
- `a_out`  out  3: port A read data.
- `r_x`  in  6: port R column.
- `r_y`  in  5: port R row.
- `r_out`  out  3: port R read data.

## Operation
Cell codes:
- 0: air
- 1: wall
- 4: enemy
- Other codes are stored verbatim.

Addressing:
- Linear address is `y*GRID_W + x`, 11 bits; maximum 1199.
- An address is out of range if `x >= GRID_W` or `y >= GRID_H`.
- Out-of-range read returns 1 (wall), so movers treat it as blocked.
- Out-of-range write is dropped.

Port A:
- Synchronous read on every cycle.
- When `a_write`=1 and the address is in range, the cell is written with `a_in`.
- `a_out` returns the pre-write contents (read-before-write).

Port R:
- Synchronous read, independent of port A.
- If port R reads the cell port A writes in the same cycle, `r_out` returns the old value.

Init sequencer FSM:
- IDLE → FILL on `init`.
- FILL → DONE after writing linear address 1199.
- DONE → IDLE unconditionally.
- `init` in FILL or DONE is ignored.

FILL behaviour:
- A counter `(fx, fy)` starts at (0,0) and steps x-major: when `fx` reaches `GRID_W-1` it wraps to 0 and `fy` increments. Exactly one cell is written per cycle.
- Written value is 1 if `fx==0`, `fx==GRID_W-1`, `fy==0` or `fy==GRID_H-1`; otherwise 0.
- Port A writes are dropped and `a_out` reads 1 (wall).
- Port R continues to read normally and may see a partially rebuilt grid.

Reset:
- State returns to IDLE and the counter clears.
- `busy`=0, `init_done`=0, `a_out`=0, `r_out`=0.
- RAM contents are not cleared.
- Reset mid-FILL aborts the rebuild: cells already written keep their new values, the rest keep old values, and no `init_done` pulse is produced.

## Timing
- Read latency is 1 cycle on both ports: an address applied before edge N gives data valid after edge N. The enemy updater's two-cycle check states satisfy this.
- Write takes effect at the edge where `a_write` is sampled; a read of the same cell in the next cycle returns the new value.
- `busy` rises the cycle after `init` is sampled and stays high for exactly 1200 cycles (FILL).
- `init_done` is high for 1 cycle (DONE), immediately after `busy` falls.
- Total time from `init` sampled to `init_done` is 1201 edges.
- Port A resumes in the cycle `init_done` is high.

## Structure
Shared package `grid_pkg`:
- `CELL_AIR`=0, `CELL_WALL`=1, `CELL_ENEMY`=4.
- `GRID_W`, `GRID_H`.
- Address width 11.
- Function `grid_addr(x, y)`.

Sub-module `grid_ram`:
- 1200×3 RAM, one write/read port and one read-only port, registered outputs, read-before-write.
- Must infer block RAM.

`grid_store` contains:
- Address/range logic.
- Write mux: the FILL counter overrides port A.
- The out-of-range/busy wall-override registers.
- The init FSM.

## Test plan
1. `reset`, then `init` → `busy` is high for 1200 cycles, then `init_done` pulses once. Reads then give: (0,0)=1, (39,29)=1, (0,15)=1, (20,0)=1, (1,1)=0, (38,28)=0, (20,15)=0.
2. After init, port A writes 4 at (5,5) with `a_write`=1 → the same-cycle `a_out`=0 (old value); the next-cycle read of (5,5) gives `a_out`=4; port R reading (5,5) one cycle later also gives 4.
3. Simultaneous port A write of 4 to (7,3) and port R read of (7,3) → `r_out`=0 that cycle, 4 on the following read.
4. Out-of-range accesses: reading (40,0) or (0,30) → `a_out`=1 and `r_out`=1. Writing 4 at (45,2) → (5,2) and all in-range cells are unchanged.
5. Writes during FILL: port A writes 4 at (10,10) at cycle 500 of FILL → `a_out`=1 during FILL; after `init_done`, (10,10)=0.
6. Reset at cycle 300 of FILL → `busy`=0 next cycle and no `init_done`. (0,7) was written at count 280 and reads 1 (wall). (25,8) is at count 345, was never written by the aborted FILL, and retains its previous value. A second `init` completes normally in 1201 edges.
